multicycle_alu: RTL and testbench

//  Parametrised, registered successor to the single-cycle ALU. Adds sub/xor/srl/sra/slt,
//  an iterative shift-add multiplier, overflow flag and valid/ready handshakes on both sides.

---
 rtl/multicycle_alu.sv | 125 ++++++++++++
 tb/tb_multicycle_alu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier; one operation in flight at a time.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [3:0]         alu_operation,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;

    // In DONE a new request may only be taken when the current result is consumed.
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign sum      = operand1 + operand2;
    assign diff     = operand1 - operand2;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_operation)
            4'd0: begin
                alu_res = sum;
                alu_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                          (sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            4'd1: alu_res = operand1 & operand2;
            4'd2: alu_res = operand1 | operand2;
            4'd3: alu_res = operand1 << shamt;
            4'd4: begin
                alu_res = diff;
                alu_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                          (diff[WIDTH-1] != operand1[WIDTH-1]);
            end
            4'd5: alu_res = operand1 ^ operand2;
            4'd6: alu_res = operand1 >> shamt;
            4'd7: alu_res = $unsigned($signed(operand1) >>> shamt);
            4'd8: alu_res = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (alu_operation == 4'd9) begin
                            mcand     <= {{WIDTH{1'b0}}, operand1};
                            mplier    <= operand2;
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else if (state == DONE && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Final step folds in the last partial product directly.
                    if (cnt == LAST) begin
                        result    <= acc_next[WIDTH-1:0];
                        zero      <= (acc_next[WIDTH-1:0] == '0);
                        overflow  <= |acc_next[2*WIDTH-1:WIDTH];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: driver pushes model results, a monitor
// pops and compares on every handshake at the output.
module tb_multicycle_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic [4:0]  shamt = '0;
    logic [3:0]  alu_operation = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   rand_rdy = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .shamt(shamt),
        .alu_operation(alu_operation), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        logic [63:0] p;
        e.op = op; e.res = '0; e.ovf = 1'b0;
        case (op)
            4'd0: begin e.res = a + b; e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]); end
            4'd1: e.res = a & b;
            4'd2: e.res = a | b;
            4'd3: e.res = a << sh;
            4'd4: begin e.res = a - b; e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]); end
            4'd5: e.res = a ^ b;
            4'd6: e.res = a >> sh;
            4'd7: e.res = $unsigned($signed(a) >>> sh);
            4'd8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; e.ovf = |p[63:32]; end
            default: e.res = '0;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Entered and left at posedge+1; holds the request until the DUT takes it.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        in_valid = 1'b1; alu_operation = op; operand1 = a; operand2 = b; shamt = sh;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(op, a, b, sh));
                @(posedge clk); #1;
                in_valid = 1'b0;
                acc_cyc = cyc;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL issue_timeout: op %0d never accepted, expected in_ready=1", op);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        case ($urandom_range(0, 3))
            0: return corners[$urandom_range(0, 4)];
            1: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare on output handshake, and check hold stability under backpressure.
    logic        held = 1'b0;
    logic [31:0] h_res;
    logic        h_zero, h_ovf;
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (out_valid && held) begin
                chk("hold_result", result, h_res);
                chk("hold_flags", {zero, overflow}, {h_zero, h_ovf});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: result %0h with empty scoreboard", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    if (result !== e.res || zero !== e.zero || overflow !== e.ovf) begin
                        errors++;
                        $display("FAIL sb_op%0d: got res=%0h z=%b ovf=%b expected res=%0h z=%b ovf=%b",
                                 e.op, result, zero, overflow, e.res, e.zero, e.ovf);
                    end
                end
            end
            held  = out_valid && !out_ready;
            h_res = result; h_zero = zero; h_ovf = overflow;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n, rdy_hits, t0;
        logic [3:0] op;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, overflow}, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        issue(4'd0, 32'd3, 32'd5, 5'd0);
        chk("add_latency", out_valid, 1);

        issue(4'd4, 32'd25, 32'd25, 5'd0);
        t0 = acc_cyc;
        issue(4'd7, 32'hFFFFFFF8, 32'd0, 5'd2);
        chk("b2b_no_bubble", acc_cyc, t0 + 1);
        chk("b2b_out_valid", out_valid, 1);

        issue(4'd0, 32'h7FFFFFFF, 32'd1, 5'd0);
        issue(4'd8, 32'hFFFFFFFD, 32'd5, 5'd0);
        issue(4'd12, 32'h1234, 32'h5678, 5'd3);

        issue(4'd9, 32'd7, 32'd6, 5'd0);
        n = 0; rdy_hits = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (in_ready) rdy_hits++;
        end
        chk("mul_busy_cycles", n, 32);
        chk("mul_in_ready_low", rdy_hits, 0);
        @(posedge clk); #1;
        issue(4'd9, 32'h10000, 32'h10000, 5'd0);

        // Backpressure: result must hold while the consumer stalls.
        issue(4'd0, 32'h11, 32'h22, 5'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset during a multiply discards it.
        issue(4'd9, 32'hDEAD, 32'hBEEF, 5'd0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_result", result, 0);
        chk("mrst_in_ready", in_ready, 1);
        sb.delete();
        reset = 1'b0;
        issue(4'd0, 32'd100, 32'd23, 5'd0);
        chk("mrst_add_valid", out_valid, 1);

        rand_rdy = 1;
        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd9 && $urandom_range(0, 1) == 0) op = 4'd0;
            issue(op, pick(), pick(), 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_rdy = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
